alu_muldiv: RTL and testbench

- Parametrised iterative multiply/divide unit alongside the single-cycle ALU in the EX stage.
- Executes MIPS MULT/MULTU/DIV/DIVU over WIDTH cycles and owns the HI/LO architectural registers.
- Also executes MTHI/MTLO.
- Exposes busy/done so the hazard unit can stall MFHI/MFLO and subsequent mul/div issue.

---
 rtl/alu_muldiv.sv | 168 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, plus MTHI/MTLO.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign a_neg = op_i[0] & a_i[WIDTH-1];
  assign b_neg = op_i[0] & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Multiply: rem_q is the running high half, quo_q holds the multiplier shifting out.
  assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], quo_q[WIDTH-1:1]};

  // Divide: partial remainder stays below the divisor, so a WIDTH-bit difference suffices.
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opb_q;
  assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_quo   = {quo_q[WIDTH-2:0], div_ge};

  assign step_hi = is_div_q ? div_rem : mul_hi;
  assign step_lo = is_div_q ? div_quo : mul_lo;

  assign prod     = {mul_hi, mul_lo};
  assign prod_fix = neg_lo_q ? -prod : prod;
  assign res_hi   = is_div_q ? (neg_hi_q ? -div_rem : div_rem) : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div_q ? (neg_lo_q ? -div_quo : div_quo) : prod_fix[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StRun: begin
        rem_d = step_hi;
        quo_d = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = '0;
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = StDone;
        end
      end
      default: begin
        // No-op codes and an absent request both fall back to idle.
        state_d = StIdle;
        if (start_i) begin
          if (!op_i[2]) begin
            state_d  = StRun;
            cnt_d    = '0;
            is_div_d = op_i[1];
            rem_d    = '0;
            if (op_i[1]) begin
              quo_d    = a_mag;
              opb_d    = b_mag;
              // Divide by zero keeps the all-ones quotient unsigned; remainder sign restores a.
              neg_lo_d = (a_neg ^ b_neg) & (b_i != '0);
              neg_hi_d = a_neg;
            end else begin
              quo_d    = b_mag;
              opb_d    = a_mag;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg ^ b_neg;
            end
          end else if (!op_i[1]) begin
            state_d = StDone;
            if (op_i[0]) begin
              lo_d = a_i;
            end else begin
              hi_d = a_i;
            end
          end
        end
      end
    endcase
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: expected HI/LO pushed at issue, popped on done_o.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [2:0]   op_i = 3'b111;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] mon_exp;
  logic [W-1:0]   mhi = '0;
  logic [W-1:0]   mlo = '0;

  alu_muldiv #(.WIDTH(W), .CNTW(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic signed [63:0] sp;
    logic signed [W-1:0] sa, sb_v;
    logic [W-1:0] q, r;
    sa = a;
    sb_v = b;
    case (op)
      3'd0: return {32'b0, a} * {32'b0, b};
      3'd1: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb_v;
        r = sa % sb_v;
        return {r, q};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 64'(done_o), 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        check_eq("result", {hi_o, lo_o}, mon_exp);
      end
    end
  end

  // Called just after a negedge; returns just after the negedge of the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int intrude);
    logic [63:0] prev, exp;
    logic [1:0]  exp_bd;
    int len;
    prev = {mhi, mlo};
    if (!op[2]) exp = model(op, a, b);
    else if (!op[0]) exp = {a, mlo};
    else exp = {mhi, a};
    sb.push_back(exp);
    {mhi, mlo} = exp;
    op_i = op;
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    op_i = 3'($urandom_range(0, 7));
    len = op[2] ? 1 : W + 1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      exp_bd = op[2] ? 2'b01 : {k <= W, k == W + 1};
      check_eq("busy_done", 64'({busy_o, done_o}), 64'(exp_bd));
      if (!op[2] && k <= W) check_eq("hold", {hi_o, lo_o}, prev);
      if (k == intrude) begin
        start_i = 1'b1;
        op_i = 3'b010;
        a_i = 32'd9;
        b_i = 32'd2;
      end else if (k == intrude + 1) begin
        start_i = 1'b0;
      end
    end
  endtask

  initial begin
    int saw;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd2, 32'd7, 32'd2, 0);
    run_op(3'd2, 32'h1234, 32'd0, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'hFFFF_FF00, 32'd0, 0);
    repeat (3) @(negedge clk);

    run_op(3'd0, 32'd3, 32'd4, 10);
    run_op(3'd2, 32'd9, 32'd2, 0);
    repeat (2) @(negedge clk);
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 0);
    @(negedge clk);
    check_eq("mt_idle", 64'({busy_o, done_o}), 64'd0);
    run_op(3'd5, 32'h1234_5678, 32'd0, 0);
    @(negedge clk);

    op_i = 3'b110;
    a_i = 32'h5555_AAAA;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    check_eq("noop_bd", 64'({busy_o, done_o}), 64'd0);
    check_eq("noop_hilo", {hi_o, lo_o}, {mhi, mlo});

    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(0, 3)), $urandom,
             (i % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom, 0);
    end
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 0);
    @(negedge clk);

    op_i = 3'd3;
    a_i = 32'hFFFF_FF00;
    b_i = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    mhi = '0;
    mlo = '0;
    #1;
    check_eq("arst_busy", 64'(busy_o), 64'd0);
    check_eq("arst_hilo", {hi_o, lo_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || busy_o) saw = 1;
    end
    check_eq("no_done_after_rst", 64'(saw), 64'd0);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
